// File: rtl/kronos_types.sv
// Shared types for the Kronos mailbox.
// Run states, word-map indices and a byte-merge helper.
package kronos_types;

  typedef enum logic [1:0] {
    MB_IDLE,
    MB_RUN,
    MB_DONE,
    MB_TIMEOUT
  } mailbox_state_e;

  localparam logic [3:0] MBOX_DONE_IDX = 4'd0;
  localparam logic [3:0] MBOX_ARG_BASE = 4'd1;

  // Replace the bytes of old_w selected by mask with new_w
  function automatic logic [31:0] mbox_merge(
    input logic [31:0] old_w,
    input logic [31:0] new_w,
    input logic [3:0]  mask
  );
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/kronos_mbox_watchdog.sv
// Mailbox run-control FSM with saturating cycle counter.
// Counter clears on start, counts in RUN, holds otherwise.
module kronos_mbox_watchdog
  import kronos_types::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rstz,
  input  logic             start,
  input  logic             done_wr,
  output mailbox_state_e   state,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  mailbox_state_e   state_d;
  logic [CNT_W-1:0] count_d;

  // State and counter registers
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state <= MB_IDLE;
      count <= '0;
    end else begin
      state <= state_d;
      count <= count_d;
    end
  end

  // Next state: done beats watchdog, start ignored while running
  always_comb begin
    state_d = state;
    count_d = count;
    unique case (state)
      MB_RUN: begin
        if (done_wr) begin
          state_d = MB_DONE;
        end else if (count == LAST) begin
          state_d = MB_TIMEOUT;
        end else if (count != '1) begin
          count_d = count + CNT_W'(1);
        end
      end
      default: begin
        if (start) begin
          state_d = MB_RUN;
          count_d = '0;
        end
      end
    endcase
  end

endmodule

// File: rtl/kronos_mailbox.sv
// Host/core mailbox: DONE word, argument words, cycle counter.
// Core side acks one cycle after each request; host reads are registered.
module kronos_mailbox
  import kronos_types::*;
#(
  parameter int NUM_ARGS = 4,
  parameter int TIMEOUT  = 1024,
  parameter int CNT_W    = 32
) (
  input  logic        clk,
  input  logic        rstz,
  input  logic [5:0]  data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_mask,
  input  logic        data_wr_en,
  input  logic        data_req,
  output logic        data_ack,
  output logic [31:0] data_rdata,
  input  logic [3:0]  host_addr,
  input  logic [31:0] host_wdata,
  input  logic        host_we,
  output logic [31:0] host_rdata,
  input  logic        host_start,
  output logic        busy,
  output logic        done,
  output logic        timeout
);

  localparam logic [3:0] CYC_IDX = 4'(NUM_ARGS + 1);

  logic [NUM_ARGS-1:0][31:0] args_q;
  logic [NUM_ARGS-1:0][31:0] args_d;

  mailbox_state_e   state;
  logic [CNT_W-1:0] count;
  logic [31:0]      cyc_word;
  logic [3:0]       data_idx;
  logic             core_wr;
  logic             done_wr;
  logic [31:0]      core_word;
  logic [31:0]      host_word;
  logic [1:0]       unused_addr;

  assign data_idx    = data_addr[5:2];
  assign unused_addr = data_addr[1:0];
  assign cyc_word    = 32'(count);
  assign core_wr     = data_req & data_wr_en;
  assign done_wr     = core_wr
                     & (data_idx == MBOX_DONE_IDX)
                     & (|data_mask)
                     & (data_wdata != '0);

  assign busy    = (state == MB_RUN);
  assign done    = (state == MB_DONE);
  assign timeout = (state == MB_TIMEOUT);

  kronos_mbox_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wdog (
    .clk     (clk),
    .rstz    (rstz),
    .start   (host_start),
    .done_wr (done_wr),
    .state   (state),
    .count   (count)
  );

  function automatic logic [31:0] word_at(
    input logic [3:0]                idx,
    input logic [NUM_ARGS-1:0][31:0] a,
    input logic                      dn,
    input logic [31:0]               cy
  );
    logic [31:0] w;
    w = '0;
    if (idx == MBOX_DONE_IDX) w = {31'b0, dn};
    if (idx == CYC_IDX)       w = cy;
    for (int i = 0; i < NUM_ARGS; i++) begin
      if (idx == MBOX_ARG_BASE + 4'(i)) w = a[i];
    end
    return w;
  endfunction

  // Read muxes for both ports
  always_comb begin
    core_word = word_at(data_idx, args_q, done, cyc_word);
    host_word = word_at(host_addr, args_q, done, cyc_word);
  end

  // Argument update: host word first, core bytes override
  always_comb begin
    logic [31:0] w;
    args_d = args_q;
    w      = '0;
    for (int i = 0; i < NUM_ARGS; i++) begin
      w = args_q[i];
      if (host_we && host_addr == MBOX_ARG_BASE + 4'(i)) begin
        w = host_wdata;
      end
      if (core_wr && data_idx == MBOX_ARG_BASE + 4'(i)) begin
        w = mbox_merge(w, data_wdata, data_mask);
      end
      args_d[i] = w;
    end
  end

  // Argument storage
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      args_q <= '0;
    end else begin
      args_q <= args_d;
    end
  end

  // Registered bus responses
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      data_ack   <= 1'b0;
      data_rdata <= '0;
      host_rdata <= '0;
    end else begin
      data_ack   <= data_req;
      data_rdata <= data_req ? core_word : '0;
      host_rdata <= host_word;
    end
  end

endmodule

// File: tb/tb_kronos_mailbox.sv
// Mailbox bench: directed scenarios then random traffic,
// all checked against a run-timestamp reference model.
module tb_kronos_mailbox;

  localparam int NA = 4;
  localparam int TO = 16;

  logic        clk;
  logic        rstz;
  logic [5:0]  data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_mask;
  logic        data_wr_en;
  logic        data_req;
  logic        data_ack;
  logic [31:0] data_rdata;
  logic [3:0]  host_addr;
  logic [31:0] host_wdata;
  logic        host_we;
  logic [31:0] host_rdata;
  logic        host_start;
  logic        busy;
  logic        done;
  logic        timeout;

  int checks;
  int errors;

  logic [31:0] marg [NA];
  logic        mrun;
  logic        mdone;
  logic        mto;
  int          n;
  int          ms;
  int          me;

  kronos_mailbox #(
    .NUM_ARGS (NA),
    .TIMEOUT  (TO),
    .CNT_W    (32)
  ) dut (
    .clk        (clk),
    .rstz       (rstz),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_mask  (data_mask),
    .data_wr_en (data_wr_en),
    .data_req   (data_req),
    .data_ack   (data_ack),
    .data_rdata (data_rdata),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_we    (host_we),
    .host_rdata (host_rdata),
    .host_start (host_start),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic mreset();
    for (int i = 0; i < NA; i++) marg[i] = '0;
    mrun  = 0;
    mdone = 0;
    mto   = 0;
    ms    = 0;
    me    = 1;
    n     = 0;
  endtask

  function automatic logic [31:0] mcyc();
    int c;
    c = mrun ? (n - ms) : (me - ms - 1);
    return 32'(c);
  endfunction

  function automatic logic [31:0] mread(input logic [3:0] idx);
    if (idx == 0) return {31'b0, mdone};
    if (idx >= 1 && idx <= NA) return marg[idx-1];
    if (idx == NA + 1) return mcyc();
    return '0;
  endfunction

  task automatic clr_in();
    data_addr  = '0;
    data_wdata = '0;
    data_mask  = '0;
    data_wr_en = 1'b0;
    data_req   = 1'b0;
    host_addr  = '0;
    host_wdata = '0;
    host_we    = 1'b0;
    host_start = 1'b0;
  endtask

  task automatic step();
    logic [31:0] e_hr;
    logic [31:0] e_dr;
    logic        e_ack;
    logic        dwr;
    logic [3:0]  di;
    di    = data_addr[5:2];
    e_hr  = mread(host_addr);
    e_ack = data_req;
    e_dr  = data_req ? mread(di) : '0;
    dwr   = data_req && data_wr_en && di == 0
            && data_mask != 0 && data_wdata != 0;
    for (int i = 0; i < NA; i++) begin
      if (host_we && host_addr == 4'(i + 1)) marg[i] = host_wdata;
      if (data_req && data_wr_en && di == 4'(i + 1)) begin
        for (int b = 0; b < 4; b++) begin
          if (data_mask[b]) marg[i][b*8 +: 8] = data_wdata[b*8 +: 8];
        end
      end
    end
    n++;
    if (!mrun && host_start) begin
      mrun  = 1;
      mdone = 0;
      mto   = 0;
      ms    = n;
    end else if (mrun && dwr) begin
      mrun  = 0;
      mdone = 1;
      me    = n;
    end else if (mrun && n - ms == TO) begin
      mrun = 0;
      mto  = 1;
      me   = n;
    end
    @(posedge clk);
    #1;
    chk("ack", data_ack, e_ack);
    chk("rdata", data_rdata, e_dr);
    chk("host_rdata", host_rdata, e_hr);
    chk("busy", busy, mrun);
    chk("done", done, mdone);
    chk("timeout", timeout, mto);
  endtask

  task automatic do_reset();
    clr_in();
    rstz = 1'b0;
    #1;
    mreset();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_to", timeout, 0);
    chk("rst_ack", data_ack, 0);
    chk("rst_rdata", data_rdata, 0);
    chk("rst_hrd", host_rdata, 0);
    @(posedge clk);
    #1;
    rstz = 1'b1;
  endtask

  task automatic core_w(logic [3:0] idx, logic [3:0] m, logic [31:0] d);
    data_req   = 1'b1;
    data_wr_en = 1'b1;
    data_addr  = {idx, 2'b00};
    data_mask  = m;
    data_wdata = d;
  endtask

  task automatic rnd_in();
    clr_in();
    host_start = ($urandom_range(0, 9) == 0);
    host_we    = ($urandom_range(0, 3) == 0);
    host_addr  = 4'($urandom_range(0, 15));
    host_wdata = $urandom;
    data_req   = 1'($urandom_range(0, 1));
    data_wr_en = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 3) == 0) data_addr = 6'($urandom_range(0, 3));
    else data_addr = 6'($urandom_range(0, 63));
    data_mask  = 4'($urandom_range(0, 15));
    data_wdata = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstz   = 1'b0;
    clr_in();
    mreset();
    repeat (2) @(posedge clk);
    #1;
    chk("init_busy", busy, 0);
    chk("init_done", done, 0);
    chk("init_to", timeout, 0);
    chk("init_ack", data_ack, 0);
    chk("init_rdata", data_rdata, 0);
    chk("init_hrd", host_rdata, 0);
    rstz = 1'b1;

    // doubler
    clr_in(); host_we = 1; host_addr = 1; host_wdata = 5; step();
    clr_in(); host_start = 1; step();
    clr_in(); core_w(2, 4'hf, 32); step();
    clr_in(); repeat (8) step();
    core_w(0, 4'h1, 1); step();
    chk("dbl_done", done, 1);
    chk("dbl_busy", busy, 0);
    clr_in(); host_addr = 2; step();
    chk("dbl_arg1", host_rdata, 32);
    host_addr = 5; step();
    chk("dbl_cyc", host_rdata, 9);
    host_addr = 1; step();
    chk("dbl_arg0", host_rdata, 5);

    // watchdog
    clr_in(); host_start = 1; step();
    clr_in(); repeat (15) step();
    chk("wd_busy", busy, 1);
    chk("wd_pre", timeout, 0);
    step();
    chk("wd_to", timeout, 1);
    chk("wd_busy0", busy, 0);
    host_addr = 5; step();
    chk("wd_cyc", host_rdata, 15);
    repeat (3) step();
    chk("wd_hold", host_rdata, 15);

    // done on the last watchdog cycle
    clr_in(); host_start = 1; step();
    clr_in(); repeat (15) step();
    core_w(0, 4'hf, 32'hdead_0001); step();
    chk("race_done", done, 1);
    chk("race_to", timeout, 0);
    clr_in(); host_addr = 5; step();
    chk("race_cyc", host_rdata, 15);

    // same-cycle ARG2 write from both ports
    clr_in();
    host_we = 1; host_addr = 3; host_wdata = 32'h1111_2222;
    core_w(3, 4'b0011, 32'hAAAA_BBBB);
    step();
    clr_in(); host_addr = 3; step();
    chk("merge_arg2", host_rdata, 32'h1111_BBBB);

    // back-to-back core reads, then ignored write to index 15
    clr_in(); data_req = 1; data_addr = 6'd0; step();
    chk("bus_ack0", data_ack, 1);
    chk("bus_rd0", data_rdata, 1);
    data_addr = 6'd4; step();
    chk("bus_ack1", data_ack, 1);
    chk("bus_rd1", data_rdata, 5);
    data_addr = 6'd60; step();
    chk("bus_ack15", data_ack, 1);
    chk("bus_rd15", data_rdata, 0);
    clr_in(); step();
    chk("bus_idle_ack", data_ack, 0);
    chk("bus_idle_rd", data_rdata, 0);
    core_w(15, 4'hf, 32'hffff_ffff); step();
    for (int a = 0; a < 16; a++) begin
      clr_in(); host_addr = 4'(a); step();
    end
    clr_in(); host_addr = 1; step();
    chk("w15_arg0", host_rdata, 5);
    host_addr = 3; step();
    chk("w15_arg2", host_rdata, 32'h1111_BBBB);

    // reset mid-run
    clr_in(); host_we = 1; host_addr = 1; host_wdata = 7; step();
    clr_in(); host_start = 1; step();
    clr_in(); repeat (10) step();
    do_reset();
    clr_in(); host_addr = 1; step();
    chk("rst_arg0", host_rdata, 0);
    clr_in(); host_start = 1; step();
    clr_in(); repeat (3) step();
    host_addr = 5; step();
    chk("rst_cnt", host_rdata, 3);

    // restart after done, start coincident with DONE write
    clr_in(); host_we = 1; host_addr = 2; host_wdata = 32'h0bad_cafe; step();
    clr_in(); core_w(0, 4'h2, 32'h100); step();
    chk("rs_done", done, 1);
    clr_in(); host_start = 1; core_w(0, 4'hf, 1); step();
    chk("rs_busy", busy, 1);
    chk("rs_done0", done, 0);
    clr_in(); repeat (4) step();
    host_start = 1; step();
    chk("rs_ign", busy, 1);
    clr_in(); host_addr = 5; step();
    chk("rs_cyc", host_rdata, 5);
    host_addr = 2; step();
    chk("rs_arg1", host_rdata, 32'h0bad_cafe);

    // random traffic
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else begin
        rnd_in();
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kronos_mailbox.md
Name: kronos_mailbox

Overview:
- Memory-mapped host/core mailbox for Kronos platform tops.
- Replaces ad-hoc "poke argument into RAM, poll done word" bring-up flows with a synthesizable block: NUM_ARGS argument/result words, a DONE register, a run-cycle counter and a watchdog.
- Sits on the core data bus beside the memory. The host side, which is the testbench or a UART bridge, preloads arguments, starts a run and reads results.
- Drives done/timeout status to platform LEDs.

Parameters:
- NUM_ARGS, 4, number of 32b argument/result words (1..14).
- TIMEOUT, 1024, run cycles before the watchdog fires (>=2).
- CNT_W, 32, width of the cycle counter (must hold TIMEOUT).

Ports:
- clk  in  1  system clock
- rstz  in  1  asynchronous active-low reset
- data_addr  in  6  core byte address, offset within the mailbox window (bits [5:2] = word index)
- data_wdata  in  32  core write data
- data_mask  in  4  core byte enables
- data_wr_en  in  1  core write strobe
- data_req  in  1  core request (block selected)
- data_ack  out  1  core acknowledge
- data_rdata  out  32  core read data, valid with data_ack
- host_addr  in  4  host word index
- host_wdata  in  32  host write data
- host_we  in  1  host write strobe
- host_rdata  out  32  host read data (registered)
- host_start  in  1  start-run pulse
- busy  out  1  run in progress
- done  out  1  core signalled completion
- timeout  out  1  watchdog expired

Behaviour:
- Word map (index):
  - 0 = DONE. Read gives {31'b0, done}. Core write with data_wdata!=0 and any mask bit set completes the run.
  - 1..NUM_ARGS = ARG[i-1], read/write.
  - NUM_ARGS+1 = CYCLES, read-only.
  - Other indices read 0; writes to them are ignored.
- Core bus:
  - data_ack is asserted exactly one cycle after data_req was sampled high; one request per ack.
  - A req held high across the ack cycle is a new request.
  - data_rdata is registered with ack; it is 0 when ack is low.
  - Writes honour data_mask per byte.
- Host port:
  - Writes take effect at the clock edge.
  - host_rdata returns the addressed word one cycle after host_addr is presented.
- FSM states: IDLE, RUN, DONE, TIMEOUT.
  - IDLE -> RUN on host_start: clears the done flag, timeout flag and cycle counter. ARGs are preserved.
  - RUN: counter increments every cycle.
  - RUN -> DONE on a core DONE write.
  - RUN -> TIMEOUT when the counter reaches TIMEOUT-1 (timeout asserts on cycle TIMEOUT after the start edge).
  - DONE/TIMEOUT -> RUN on host_start, with the same clearing as from IDLE.
  - host_start while in RUN is ignored.
- Outputs by state: busy=1 only in RUN; done=1 only in DONE; timeout=1 only in TIMEOUT. The counter holds its value in DONE and TIMEOUT.
- Simultaneous events:
  - A DONE write in the same cycle the counter reaches TIMEOUT-1 goes to DONE (done wins).
  - Core and host write the same ARG in the same cycle: the core write wins for enabled bytes; the host value applies to the other bytes.
  - host_start coincident with a core DONE write in DONE/TIMEOUT: start wins.
- Core DONE writes outside RUN are acked and have no effect.
- Reset (async, any state):
  - State -> IDLE.
  - ARGs, counter, data_ack, data_rdata, host_rdata all 0.
  - busy/done/timeout all 0.
- Counter saturates at all-ones and never wraps.

Decomposition:
- kronos_types gains:
  - mailbox_state_e (IDLE/RUN/DONE/TIMEOUT)
  - MBOX_DONE_IDX = 0
  - MBOX_ARG_BASE = 1
- The CYCLES index is derived locally from NUM_ARGS.
- One natural sub-module, kronos_mbox_watchdog: FSM plus saturating counter. Inputs start/done_wr; outputs state/count.

Test Plan:
- Doubler: host writes ARG0=5, pulses start; core-model writes ARG1=32, then DONE=1 at cycle 40 -> done=1, busy=0, host reads ARG1=32 and CYCLES=40.
- Watchdog (TIMEOUT=16): start, no DONE write -> timeout=1 exactly 16 cycles after start, busy=0, CYCLES=15 and held.
- Race: DONE write lands on the cycle the counter hits TIMEOUT-1 -> done=1, timeout=0. Separately, core mask=4'b0011 data 0xAAAA_BBBB and host 0x1111_2222 to ARG2 in the same cycle -> ARG2=0x1111_BBBB.
- Bus protocol: back-to-back reads of index 0, 1, 15 -> ack one cycle after each req; rdata 0, ARG0, 0; writes to index 15 leave all registers unchanged.
- Reset mid-run: deassert rstz 10 cycles into RUN with ARG0=7 -> busy/done/timeout=0, ARG0=0. A new start from IDLE counts from 0.
- Restart: after DONE, pulse start with ARGs preserved -> busy=1, done=0, counter restarts at 0; start pulsed again in RUN is ignored.
